// File: rtl/mem_access_stage_if.sv
// Bundles the upstream op, data-memory and writeback handshakes of mem_access_stage.
// The master modport is the stage itself. The slave modport is its surroundings.
interface mem_access_stage_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 8,
    parameter int PREG_W = 5,
    parameter int ROB_W  = 5
);
    logic [ADDR_W-1:0] in_addr;
    logic              in_store;
    logic [DATA_W-1:0] in_data;
    logic [PREG_W-1:0] in_dest_reg;
    logic [7:0]        in_dest_arch_regs;
    logic [ROB_W-1:0]  in_rob_entry;
    logic              in_valid;
    logic              in_ready;

    logic              mem_req_valid;
    logic              mem_req_ready;
    logic [ADDR_W-1:0] mem_req_addr;
    logic              mem_req_we;
    logic [DATA_W-1:0] mem_req_wdata;
    logic              mem_resp_valid;
    logic [DATA_W-1:0] mem_resp_data;

    logic              wb_valid;
    logic              wb_ready;
    logic [DATA_W-1:0] wb_data;
    logic [PREG_W-1:0] wb_dest_reg;
    logic [7:0]        wb_dest_arch_regs;
    logic [ROB_W-1:0]  wb_rob_entry;
    logic              wb_is_store;
    logic              wb_flag_n;
    logic              wb_flag_z;

    modport master (
        input  in_addr, in_store, in_data, in_dest_reg, in_dest_arch_regs, in_rob_entry,
        input  in_valid,
        output in_ready,
        output mem_req_valid, mem_req_addr, mem_req_we, mem_req_wdata,
        input  mem_req_ready,
        input  mem_resp_valid, mem_resp_data,
        output wb_valid, wb_data, wb_dest_reg, wb_dest_arch_regs, wb_rob_entry,
        output wb_is_store, wb_flag_n, wb_flag_z,
        input  wb_ready
    );

    modport slave (
        output in_addr, in_store, in_data, in_dest_reg, in_dest_arch_regs, in_rob_entry,
        output in_valid,
        input  in_ready,
        input  mem_req_valid, mem_req_addr, mem_req_we, mem_req_wdata,
        output mem_req_ready,
        output mem_resp_valid, mem_resp_data,
        input  wb_valid, wb_data, wb_dest_reg, wb_dest_arch_regs, wb_rob_entry,
        input  wb_is_store, wb_flag_n, wb_flag_z,
        output wb_ready
    );
endinterface

// File: rtl/mem_access_stage.sv
// Memory access stage: issues one resolved load/store to the data memory and
// presents the completed op (load data with N/Z flags) to writeback, one op at a time.
module mem_access_stage #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 8,
    parameter int PREG_W = 5,
    parameter int ROB_W  = 5
) (
    input  logic                clk,
    input  logic                rst_n,
    mem_access_stage_if.master  bus
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] REQ  = 2'd1;
    localparam logic [1:0] WAIT = 2'd2;
    localparam logic [1:0] DONE = 2'd3;

    logic [1:0]        state;

    logic [ADDR_W-1:0] addr_p0;
    logic              store_p0;
    logic [DATA_W-1:0] wdata_p0;
    logic [PREG_W-1:0] dest_reg_p0;
    logic [7:0]        arch_p0;
    logic [ROB_W-1:0]  rob_p0;

    logic signed [DATA_W-1:0] data_p1;
    logic              flag_n_p1;
    logic              flag_z_p1;
    logic              is_store_p1;
    logic [PREG_W-1:0] dest_reg_p1;
    logic [7:0]        arch_p1;
    logic [ROB_W-1:0]  rob_p1;

    logic ready;
    logic accept;
    logic req_fire;
    logic resp_fire;

    // {N, Z} of a load result, treating the data as two's complement.
    function automatic logic [1:0] nz_flags(input logic signed [DATA_W-1:0] d);
        return {d < 0, d == '0};
    endfunction

    assign ready     = (state == IDLE) | ((state == DONE) & bus.wb_ready);
    assign accept    = bus.in_valid & ready;
    assign req_fire  = (state == REQ) & bus.mem_req_ready;
    assign resp_fire = (state == WAIT) & bus.mem_resp_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE:    if (accept) state <= REQ;
                REQ:     if (bus.mem_req_ready) state <= store_p0 ? DONE : WAIT;
                WAIT:    if (bus.mem_resp_valid) state <= DONE;
                DONE:    if (bus.wb_ready) state <= accept ? REQ : IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // p0: op fields captured at acceptance, held stable while the request is outstanding
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_p0     <= '0;
            store_p0    <= 1'b0;
            wdata_p0    <= '0;
            dest_reg_p0 <= '0;
            arch_p0     <= '0;
            rob_p0      <= '0;
        end else if (accept) begin
            addr_p0     <= bus.in_addr;
            store_p0    <= bus.in_store;
            wdata_p0    <= bus.in_data;
            dest_reg_p0 <= bus.in_dest_reg;
            arch_p0     <= bus.in_dest_arch_regs;
            rob_p0      <= bus.in_rob_entry;
        end
    end

    // p1: completion record, written once per op and held through writeback backpressure
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_p1     <= '0;
            flag_n_p1   <= 1'b0;
            flag_z_p1   <= 1'b0;
            is_store_p1 <= 1'b0;
            dest_reg_p1 <= '0;
            arch_p1     <= '0;
            rob_p1      <= '0;
        end else if ((req_fire & store_p0) | resp_fire) begin
            dest_reg_p1 <= dest_reg_p0;
            arch_p1     <= arch_p0;
            rob_p1      <= rob_p0;
            is_store_p1 <= store_p0;
            if (store_p0) begin
                data_p1   <= '0;
                flag_n_p1 <= 1'b0;
                flag_z_p1 <= 1'b0;
            end else begin
                data_p1                <= bus.mem_resp_data;
                {flag_n_p1, flag_z_p1} <= nz_flags(bus.mem_resp_data);
            end
        end
    end

    assign bus.in_ready          = ready;
    assign bus.mem_req_valid     = (state == REQ);
    assign bus.mem_req_addr      = addr_p0;
    assign bus.mem_req_we        = store_p0;
    assign bus.mem_req_wdata     = wdata_p0;
    assign bus.wb_valid          = (state == DONE);
    assign bus.wb_data           = data_p1;
    assign bus.wb_dest_reg       = dest_reg_p1;
    assign bus.wb_dest_arch_regs = arch_p1;
    assign bus.wb_rob_entry      = rob_p1;
    assign bus.wb_is_store       = is_store_p1;
    assign bus.wb_flag_n         = flag_n_p1;
    assign bus.wb_flag_z         = flag_z_p1;
endmodule

// File: doc/mem_access_stage.md
Name: mem_access_stage

Overview:
- Execution stage directly downstream of the memory address-generation pipeline.
- Takes one resolved memory op per handshake: 16-bit address, load/store flag, store data, physical destination, architectural-destination mask and ROB entry.
- Issues the op on a valid/ready data-memory port; stores complete on acceptance, loads wait for a response.
- Presents the completed op to writeback/ROB, with N/Z flags computed from load data.

Parameters:
ADDR_W, 16, memory address width
DATA_W, 8, data width
PREG_W, 5, physical register tag width
ROB_W, 5, ROB entry index width

Ports:
clk  in  1  clock; all state updates on rising edge
rst_n  in  1  asynchronous active-low reset
in_addr  in  ADDR_W  effective address from address generation
in_store  in  1  1 = store, 0 = load
in_data  in  DATA_W  store data (ignored for loads)
in_dest_reg  in  PREG_W  physical destination (loads)
in_dest_arch_regs  in  8  architectural destination/flag mask, passed through
in_rob_entry  in  ROB_W  ROB index, passed through
in_valid  in  1  upstream op valid
in_ready  out  1  stage can accept op
mem_req_valid  out  1  memory request valid
mem_req_ready  in  1  memory accepts request
mem_req_addr  out  ADDR_W  request address
mem_req_we  out  1  1 = write
mem_req_wdata  out  DATA_W  write data
mem_resp_valid  in  1  load data valid
mem_resp_data  in  DATA_W  load data
wb_valid  out  1  completed op valid
wb_ready  in  1  writeback/ROB accepts completion
wb_data  out  DATA_W  load data (0 for stores)
wb_dest_reg  out  PREG_W  physical destination
wb_dest_arch_regs  out  8  pass-through mask
wb_rob_entry  out  ROB_W  ROB index
wb_is_store  out  1  completion is a store
wb_flag_n  out  1  wb_data[DATA_W-1] (0 for stores)
wb_flag_z  out  1  wb_data == 0 (0 for stores)

Behaviour:
- Reset (rst_n low, asynchronous): state IDLE; all outputs and registered fields 0; mem_req_valid and wb_valid drop immediately. An in-flight op is discarded. A mem_resp_valid arriving after reset while IDLE is ignored.
- States: IDLE, REQ, WAIT, DONE. All outputs are driven from registers or decoded from state only; no combinational path from in_* or mem_resp_* to any output.
- in_ready = (state==IDLE) | (state==DONE & wb_ready).
- Accept (in_valid & in_ready at the edge):
  - Latch all in_* fields.
  - Go to REQ.
  - In DONE with wb_ready, completion and acceptance happen on the same edge.
- DONE & wb_ready with no accept: go to IDLE; wb_valid falls.
- REQ: mem_req_valid=1; mem_req_addr, mem_req_we and mem_req_wdata come from latched fields and are stable while waiting. On mem_req_ready at the edge:
  - Store: go to DONE; wb_is_store=1; wb_data, wb_flag_n and wb_flag_z are 0.
  - Load: go to WAIT.
- WAIT: on mem_resp_valid, capture mem_resp_data into wb_data, compute N/Z, go to DONE.
  - Response latency from request acceptance is at least 1 cycle and otherwise unbounded.
  - mem_resp_valid in any state other than WAIT is ignored.
- DONE: wb_valid=1. All wb_* fields hold stable until the edge where wb_ready is high.
- Minimum latency, accept to wb_valid:
  - Store: 2 cycles (mem_req_ready already high).
  - Load: 3 cycles (response 1 cycle after acceptance).
- Throughput: at most one op outstanding. Best-case issue rate is one op per 2 cycles for stores and one per 3 cycles for loads.
- Address is used as-is; no arithmetic in this stage, and no wrap handling needed here.

Test Plan:
- Reset mid-load: accept load addr 0x0200, then assert rst_n=0 while in WAIT. Required: mem_req_valid=0 and wb_valid=0 immediately. A later mem_resp_valid is ignored and the next accept behaves normally.
- Store, ready memory: in_addr=0x1234, in_store=1, in_data=0xA5, rob=3, mem_req_ready=1. Required: mem_req_valid one cycle after accept with we=1, wdata=0xA5; wb_valid next cycle with is_store=1, data=0, rob=3.
- Load, negative value: addr 0x00FF, dest_reg=7, dest_arch_regs=0x81, memory ready, response 0x80 three cycles after request. Required: wb_valid the cycle after the response with data=0x80, N=1, Z=0, dest_reg=7, arch=0x81; in_ready=0 throughout.
- Load zero with stalls: mem_req_ready low for 4 cycles, then response 0x00. Required: request fields stable while stalled; completion with Z=1, N=0.
- Writeback backpressure plus back-to-back: wb_ready=0 for 3 cycles with a second op (store 0x0300/0x11) waiting. Required: wb_* stable and in_ready=0. When wb_ready=1, completion and acceptance occur on the same edge and the second op issues next cycle.
- Spurious response: mem_resp_valid=1 with data 0x55 while IDLE and while in REQ. Required: no state change, no wb_valid, and the following load returns its own response data.
